// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD ALU sequencer.
//
// Contents:
//   seqState_t  : sequencer state encoding (IDLE / RUN / DRAIN)
//   FN_*        : ALU function codes that the ALU understands
//   DEFAULT_*   : default widths used as parameter defaults
package simd_pkg;

    localparam int DEFAULT_FUNCTION_BITS = 4;
    localparam int DEFAULT_BIT_WIDTH     = 32;
    localparam int DEFAULT_ADDR_WIDTH    = 10;
    localparam int DEFAULT_COUNT_WIDTH   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seqState_t;

    localparam logic [3:0] FN_ADD = 4'd0;
    localparam logic [3:0] FN_SUB = 4'd1;
    localparam logic [3:0] FN_AND = 4'd2;
    localparam logic [3:0] FN_OR  = 4'd3;
    localparam logic [3:0] FN_XOR = 4'd4;
    localparam logic [3:0] FN_MUL = 4'd5;
    localparam logic [3:0] FN_MAC = 4'd6;
    localparam logic [3:0] FN_SHR = 4'd7;
    localparam logic [3:0] FN_SHL = 4'd8;

endpackage

// File: rtl/simd_seq_addr_gen.sv
// Address generator: a base register plus an offset counter.
// The output address is base + offset, wrapping modulo 2^ADDR_WIDTH.
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   i_load      : capture i_base and clear the offset
//   i_base      : start address
//   i_advance   : step the offset by one
//   o_addr      : current address (base + offset)
module simd_seq_addr_gen
    import simd_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic                  i_advance,
    output logic [ADDR_WIDTH-1:0] o_addr
);

    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_offset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_base   <= '0;
            r_offset <= '0;
        end else if (i_load) begin
            r_base   <= i_base;
            r_offset <= '0;
        end else if (i_advance) begin
            r_offset <= r_offset + ADDR_WIDTH'(1);
        end
    end

    // Same-width sum: carry out is dropped, giving the modulo wrap.
    assign o_addr = r_base + r_offset;

endmodule

// File: rtl/simd_alu_sequencer.sv
// simd_alu_sequencer: accepts one vector command, streams operand reads
// from the scratchpad into the ALU and writes each registered result back.
//
// Pipeline per element i (command accepted in cycle A):
//   A+1+i : rd_en, rd_addr0/1
//   A+2+i : read data arrives, driven onto the ALU inputs
//   A+3+i : wr_en with the registered ALU result
//
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   cmd_valid/cmd_ready, cmd_*         : command handshake and fields
//   rd_en, rd_addr0/1, rd_data0/1      : scratchpad read port
//   alu_fn, alu_in0/1, alu_acc, alu_out: ALU interface
//   wr_en, wr_addr, wr_data            : scratchpad write port
//   busy, done                         : status
//
// Optional feature: define SIMD_SEQ_REDUCE_EN to add cmd_reduce, which
// chains each result into the next element and writes only the final one.
module simd_alu_sequencer
    import simd_pkg::*;
#(
    parameter int FUNCTION_BITS = DEFAULT_FUNCTION_BITS,
    parameter int BIT_WIDTH     = DEFAULT_BIT_WIDTH,
    parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
    parameter int COUNT_WIDTH   = DEFAULT_COUNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [FUNCTION_BITS-1:0] cmd_fn,
    input  logic [ADDR_WIDTH-1:0]    cmd_src0_base,
    input  logic [ADDR_WIDTH-1:0]    cmd_src1_base,
    input  logic [ADDR_WIDTH-1:0]    cmd_dst_base,
    input  logic [COUNT_WIDTH-1:0]   cmd_count,
`ifdef SIMD_SEQ_REDUCE_EN
    input  logic                     cmd_reduce,
`endif
    output logic                     rd_en,
    output logic [ADDR_WIDTH-1:0]    rd_addr0,
    output logic [ADDR_WIDTH-1:0]    rd_addr1,
    input  logic [BIT_WIDTH-1:0]     rd_data0,
    input  logic [BIT_WIDTH-1:0]     rd_data1,
    output logic [FUNCTION_BITS-1:0] alu_fn,
    output logic [BIT_WIDTH-1:0]     alu_in0,
    output logic [BIT_WIDTH-1:0]     alu_in1,
    output logic [BIT_WIDTH-1:0]     alu_acc,
    input  logic [BIT_WIDTH-1:0]     alu_out,
    output logic                     wr_en,
    output logic [ADDR_WIDTH-1:0]    wr_addr,
    output logic [BIT_WIDTH-1:0]     wr_data,
    output logic                     busy,
    output logic                     done
);

    seqState_t              r_state;
    logic                   r_cmdReady;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_rdEn;
    logic [FUNCTION_BITS-1:0] r_fn;
    logic [COUNT_WIDTH-1:0] r_remaining;

    logic                   r_s2Valid;
    logic                   r_s2Last;
    logic                   r_wrEn;
    logic [BIT_WIDTH-1:0]   r_wrData;
    logic [FUNCTION_BITS-1:0] r_fnHold;
    logic [BIT_WIDTH-1:0]   r_in0Hold;
    logic [BIT_WIDTH-1:0]   r_in1Hold;

    logic                   w_accept;
    logic                   w_lastRead;
    logic                   w_writeNow;
    logic [BIT_WIDTH-1:0]   w_in1Now;

    assign w_accept   = cmd_valid && r_cmdReady;
    assign w_lastRead = r_rdEn && (r_remaining == COUNT_WIDTH'(1));

    simd_seq_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_src0Gen (
        .clk(clk), .reset(reset), .i_load(w_accept), .i_base(cmd_src0_base),
        .i_advance(r_rdEn), .o_addr(rd_addr0)
    );

    simd_seq_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_src1Gen (
        .clk(clk), .reset(reset), .i_load(w_accept), .i_base(cmd_src1_base),
        .i_advance(r_rdEn), .o_addr(rd_addr1)
    );

    // Destination steps after each write, so it always points at the next result.
    simd_seq_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_dstGen (
        .clk(clk), .reset(reset), .i_load(w_accept), .i_base(cmd_dst_base),
        .i_advance(r_wrEn), .o_addr(wr_addr)
    );

`ifdef SIMD_SEQ_REDUCE_EN
    logic                 r_reduce;
    logic                 r_firstRead;
    logic                 r_s2First;
    logic [BIT_WIDTH-1:0] r_acc;
    logic [BIT_WIDTH-1:0] r_accHold;
    logic [BIT_WIDTH-1:0] w_accNow;

    // In reduce mode every element after the first chains the running result.
    assign w_accNow   = r_reduce ? r_acc : '0;
    assign w_in1Now   = (r_reduce && !r_s2First) ? r_acc : rd_data1;
    assign w_writeNow = r_s2Valid && (!r_reduce || r_s2Last);
    assign alu_acc    = r_s2Valid ? w_accNow : r_accHold;
`else
    assign w_in1Now   = rd_data1;
    assign w_writeNow = r_s2Valid;
    assign alu_acc    = '0;
`endif

    // ALU inputs follow live read data while an element is in stage 2,
    // otherwise they replay the last element's values.
    assign alu_fn  = r_s2Valid ? r_fn     : r_fnHold;
    assign alu_in0 = r_s2Valid ? rd_data0 : r_in0Hold;
    assign alu_in1 = r_s2Valid ? w_in1Now : r_in1Hold;

    assign cmd_ready = r_cmdReady;
    assign busy      = r_busy;
    assign done      = r_done;
    assign rd_en     = r_rdEn;
    assign wr_en     = r_wrEn;
    assign wr_data   = r_wrData;

    // Control FSM. done follows the last element out of stage 2, which lines
    // it up with the final write; DRAIN exits on that same done cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cmdReady  <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rdEn      <= 1'b0;
            r_fn        <= '0;
            r_remaining <= '0;
`ifdef SIMD_SEQ_REDUCE_EN
            r_reduce    <= 1'b0;
            r_firstRead <= 1'b0;
`endif
        end else begin
            r_done <= r_s2Last;
`ifdef SIMD_SEQ_REDUCE_EN
            if (w_accept) begin
                r_reduce    <= cmd_reduce;
                r_firstRead <= 1'b1;
            end else if (r_rdEn) begin
                r_firstRead <= 1'b0;
            end
`endif
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_fn        <= cmd_fn;
                        r_remaining <= cmd_count;
                        if (cmd_count == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state    <= RUN;
                            r_rdEn     <= 1'b1;
                            r_busy     <= 1'b1;
                            r_cmdReady <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    r_remaining <= r_remaining - COUNT_WIDTH'(1);
                    if (w_lastRead) begin
                        r_rdEn  <= 1'b0;
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (r_done) begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_cmdReady <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Datapath pipeline: stage-2 tracking, result register and ALU hold values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2Valid <= 1'b0;
            r_s2Last  <= 1'b0;
            r_wrEn    <= 1'b0;
            r_wrData  <= '0;
            r_fnHold  <= '0;
            r_in0Hold <= '0;
            r_in1Hold <= '0;
`ifdef SIMD_SEQ_REDUCE_EN
            r_s2First <= 1'b0;
            r_acc     <= '0;
            r_accHold <= '0;
`endif
        end else begin
            r_s2Valid <= r_rdEn;
            r_s2Last  <= w_lastRead;
            r_wrEn    <= w_writeNow;
            if (w_writeNow) begin
                r_wrData <= alu_out;
            end
            if (r_s2Valid) begin
                r_fnHold  <= r_fn;
                r_in0Hold <= rd_data0;
                r_in1Hold <= w_in1Now;
            end
`ifdef SIMD_SEQ_REDUCE_EN
            r_s2First <= r_rdEn && r_firstRead;
            if (w_accept) begin
                r_acc <= '0;
            end else if (r_s2Valid && r_reduce) begin
                r_acc <= alu_out;
            end
            if (r_s2Valid) begin
                r_accHold <= w_accNow;
            end
`endif
        end
    end

endmodule

// File: tb/tb_simd_alu_sequencer.sv
// Directed testbench for simd_alu_sequencer. Provides a scratchpad with
// one-cycle read latency and a saturating ALU, then walks through hand-timed
// commands checking ports cycle by cycle.
module tb_simd_alu_sequencer;
    import simd_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmdValid;
    logic        cmdReady;
    logic [3:0]  cmdFn;
    logic [9:0]  cmdSrc0, cmdSrc1, cmdDst;
    logic [15:0] cmdCount;
    logic        cmdReduce;
    logic        rdEn;
    logic [9:0]  rdAddr0, rdAddr1;
    logic [31:0] rdData0 = '0;
    logic [31:0] rdData1 = '0;
    logic [3:0]  aluFn;
    logic [31:0] aluIn0, aluIn1, aluAcc, aluOut;
    logic        wrEn;
    logic [9:0]  wrAddr;
    logic [31:0] wrData;
    logic        busy, done;

    logic [31:0] mem [0:1023];
    int total = 0;
    int bad   = 0;

    simd_alu_sequencer dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmdValid), .cmd_ready(cmdReady), .cmd_fn(cmdFn),
        .cmd_src0_base(cmdSrc0), .cmd_src1_base(cmdSrc1),
        .cmd_dst_base(cmdDst), .cmd_count(cmdCount),
`ifdef SIMD_SEQ_REDUCE_EN
        .cmd_reduce(cmdReduce),
`endif
        .rd_en(rdEn), .rd_addr0(rdAddr0), .rd_addr1(rdAddr1),
        .rd_data0(rdData0), .rd_data1(rdData1),
        .alu_fn(aluFn), .alu_in0(aluIn0), .alu_in1(aluIn1), .alu_acc(aluAcc),
        .alu_out(aluOut),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Scratchpad: read data valid the cycle after rd_en.
    always @(posedge clk) begin
        if (rdEn) begin
            rdData0 <= mem[rdAddr0];
            rdData1 <= mem[rdAddr1];
        end
    end

    // Saturating ALU model.
    logic signed [32:0] aluSum;
    always_comb begin
        aluSum = '0;
        aluOut = aluIn0;
        case (aluFn)
            FN_ADD, FN_SUB: begin
                if (aluFn == FN_ADD)
                    aluSum = {aluIn0[31], aluIn0} + {aluIn1[31], aluIn1};
                else
                    aluSum = {aluIn0[31], aluIn0} - {aluIn1[31], aluIn1};
                if (aluSum[32] != aluSum[31])
                    aluOut = aluSum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                else
                    aluOut = aluSum[31:0];
            end
            FN_SHR:  aluOut = $signed(aluIn0) >>> aluIn1[4:0];
            FN_SHL:  aluOut = aluIn0 << aluIn1[4:0];
            default: aluOut = aluIn0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Presents a command in the current cycle (A); returns sampled in A+1.
    task automatic applyStimulus(input logic [3:0] fn, input logic [9:0] s0, input logic [9:0] s1,
                                 input logic [9:0] dst, input logic [15:0] count, input logic reduce);
        cmdFn     = fn;
        cmdSrc0   = s0;
        cmdSrc1   = s1;
        cmdDst    = dst;
        cmdCount  = count;
        cmdReduce = reduce;
        cmdValid  = 1'b1;
        checkOutput("accept_ready", {31'd0, cmdReady}, 32'd1);
        tick();
        cmdValid  = 1'b0;
        cmdReduce = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic sawWrite;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        for (int i = 0; i < 4; i++) begin
            mem[16 + i] = 32'(i + 1);
            mem[32 + i] = 32'(10 * (i + 1));
        end
        mem[100]  = 32'h8000_0000;
        mem[101]  = 32'd1;
        mem[1022] = 32'd5;
        mem[1023] = 32'd6;
        mem[0]    = 32'd7;
        mem[300]  = 32'd1000;
        mem[301]  = 32'd2000;
        mem[302]  = 32'd3000;
        mem[40]   = 32'd100;

        cmdValid = 1'b0; cmdFn = '0; cmdSrc0 = '0; cmdSrc1 = '0; cmdDst = '0;
        cmdCount = '0; cmdReduce = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        $display("[TB] reset values");
        checkOutput("rst_ready",  {31'd0, cmdReady}, 32'd1);
        checkOutput("rst_rd_en",  {31'd0, rdEn}, 32'd0);
        checkOutput("rst_wr_en",  {31'd0, wrEn}, 32'd0);
        checkOutput("rst_busy",   {31'd0, busy}, 32'd0);
        checkOutput("rst_done",   {31'd0, done}, 32'd0);
        checkOutput("rst_addr0",  {22'd0, rdAddr0}, 32'd0);
        checkOutput("rst_wraddr", {22'd0, wrAddr}, 32'd0);
        checkOutput("rst_wrdata", wrData, 32'd0);
        checkOutput("rst_alu_in0", aluIn0, 32'd0);
        checkOutput("rst_alu_acc", aluAcc, 32'd0);
        reset = 1'b0;
        tick();

        // ADD, count=4.
        $display("[TB] ADD count=4");
        applyStimulus(FN_ADD, 10'd16, 10'd32, 10'd64, 16'd4, 1'b0);
        checkOutput("add_rd_en_a1", {31'd0, rdEn}, 32'd1);
        checkOutput("add_addr0_a1", {22'd0, rdAddr0}, 32'd16);
        checkOutput("add_addr1_a1", {22'd0, rdAddr1}, 32'd32);
        checkOutput("add_busy_a1",  {31'd0, busy}, 32'd1);
        checkOutput("add_ready_a1", {31'd0, cmdReady}, 32'd0);
        tick();
        // A command offered while busy must be ignored.
        cmdValid = 1'b1; cmdCount = 16'd9; cmdDst = 10'd5;
        checkOutput("add_alu_in0_a2", aluIn0, 32'd1);
        checkOutput("add_alu_in1_a2", aluIn1, 32'd10);
        checkOutput("add_alu_fn_a2",  {28'd0, aluFn}, {28'd0, FN_ADD});
        checkOutput("add_wr_en_a2",   {31'd0, wrEn}, 32'd0);
        tick();
        cmdValid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("add_wr_en_%0d", k), {31'd0, wrEn}, 32'd1);
            checkOutput($sformatf("add_wr_addr_%0d", k), {22'd0, wrAddr}, 32'(64 + k));
            checkOutput($sformatf("add_wr_data_%0d", k), wrData, 32'(11 * (k + 1)));
            checkOutput($sformatf("add_done_%0d", k), {31'd0, done}, {31'd0, k == 3});
            checkOutput($sformatf("add_rd_en_%0d", k), {31'd0, rdEn}, {31'd0, k <= 1});
            tick();
        end
        checkOutput("add_wr_en_end", {31'd0, wrEn}, 32'd0);
        checkOutput("add_busy_end",  {31'd0, busy}, 32'd0);
        checkOutput("add_ready_end", {31'd0, cmdReady}, 32'd1);
        checkOutput("add_done_end",  {31'd0, done}, 32'd0);
        checkOutput("add_hold_in0",  aluIn0, 32'd4);
        checkOutput("add_hold_in1",  aluIn1, 32'd40);

        // SUB saturation, count=1.
        $display("[TB] SUB saturation");
        applyStimulus(FN_SUB, 10'd100, 10'd101, 10'd200, 16'd1, 1'b0);
        checkOutput("sub_busy_a1", {31'd0, busy}, 32'd1);
        tick();
        checkOutput("sub_busy_a2",  {31'd0, busy}, 32'd1);
        checkOutput("sub_rd_en_a2", {31'd0, rdEn}, 32'd0);
        checkOutput("sub_alu_fn",   {28'd0, aluFn}, {28'd0, FN_SUB});
        tick();
        checkOutput("sub_wr_en",   {31'd0, wrEn}, 32'd1);
        checkOutput("sub_wr_data", wrData, 32'h8000_0000);
        checkOutput("sub_wr_addr", {22'd0, wrAddr}, 32'd200);
        checkOutput("sub_done",    {31'd0, done}, 32'd1);
        checkOutput("sub_busy_a3", {31'd0, busy}, 32'd1);
        tick();
        checkOutput("sub_busy_a4", {31'd0, busy}, 32'd0);

        // count=0.
        $display("[TB] count=0");
        applyStimulus(FN_ADD, 10'd16, 10'd32, 10'd64, 16'd0, 1'b0);
        checkOutput("zero_done_a1",  {31'd0, done}, 32'd1);
        checkOutput("zero_rd_en_a1", {31'd0, rdEn}, 32'd0);
        checkOutput("zero_wr_en_a1", {31'd0, wrEn}, 32'd0);
        checkOutput("zero_ready_a1", {31'd0, cmdReady}, 32'd1);
        tick();
        checkOutput("zero_done_a2",  {31'd0, done}, 32'd0);
        checkOutput("zero_rd_en_a2", {31'd0, rdEn}, 32'd0);
        checkOutput("zero_ready_a2", {31'd0, cmdReady}, 32'd1);

        // Address wrap.
        $display("[TB] address wrap");
        applyStimulus(FN_ADD, 10'd1022, 10'd300, 10'd500, 16'd3, 1'b0);
        checkOutput("wrap_addr0_0", {22'd0, rdAddr0}, 32'd1022);
        tick();
        checkOutput("wrap_addr0_1", {22'd0, rdAddr0}, 32'd1023);
        tick();
        checkOutput("wrap_addr0_2", {22'd0, rdAddr0}, 32'd0);
        checkOutput("wrap_wr_data0", wrData, 32'd1005);
        tick();
        tick();
        checkOutput("wrap_wr_data2", wrData, 32'd3007);
        checkOutput("wrap_wr_addr2", {22'd0, wrAddr}, 32'd502);
        checkOutput("wrap_done",     {31'd0, done}, 32'd1);
        tick();

        // Reset in the middle of a count=8 command.
        $display("[TB] mid-command reset");
        applyStimulus(FN_ADD, 10'd16, 10'd32, 10'd64, 16'd8, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mid_ready", {31'd0, cmdReady}, 32'd1);
        checkOutput("mid_busy",  {31'd0, busy}, 32'd0);
        checkOutput("mid_rd_en", {31'd0, rdEn}, 32'd0);
        sawWrite = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (wrEn) sawWrite = 1'b1;
            tick();
        end
        checkOutput("mid_no_write", {31'd0, sawWrite}, 32'd0);
        applyStimulus(FN_ADD, 10'd16, 10'd32, 10'd80, 16'd2, 1'b0);
        tick();
        tick();
        checkOutput("mid2_wr_data0", wrData, 32'd11);
        checkOutput("mid2_wr_addr0", {22'd0, wrAddr}, 32'd80);
        tick();
        checkOutput("mid2_wr_data1", wrData, 32'd22);
        checkOutput("mid2_wr_addr1", {22'd0, wrAddr}, 32'd81);
        checkOutput("mid2_done",     {31'd0, done}, 32'd1);
        tick();

`ifdef SIMD_SEQ_REDUCE_EN
        // Reduction: 1+100, +2, +3, +4 -> 110 written once.
        $display("[TB] reduce");
        applyStimulus(FN_ADD, 10'd16, 10'd40, 10'd90, 16'd4, 1'b1);
        tick();
        checkOutput("red_in1_a2", aluIn1, 32'd100);
        tick();
        checkOutput("red_wr_en_a3", {31'd0, wrEn}, 32'd0);
        tick();
        checkOutput("red_wr_en_a4", {31'd0, wrEn}, 32'd0);
        tick();
        checkOutput("red_wr_en_a5", {31'd0, wrEn}, 32'd0);
        checkOutput("red_in1_a5",   aluIn1, 32'd106);
        checkOutput("red_acc_a5",   aluAcc, 32'd106);
        tick();
        checkOutput("red_wr_en_a6",   {31'd0, wrEn}, 32'd1);
        checkOutput("red_wr_data_a6", wrData, 32'd110);
        checkOutput("red_wr_addr_a6", {22'd0, wrAddr}, 32'd90);
        checkOutput("red_done_a6",    {31'd0, done}, 32'd1);
        tick();
        checkOutput("red_wr_en_a7", {31'd0, wrEn}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/simd_alu_sequencer.md
# simd_alu_sequencer

Command-driven issue engine for the SIMD arithmetic unit. It accepts one vector command (function code, two source bases, one destination base, element count) and streams operand reads from the SIMD scratchpad into the ALU. It registers each ALU result and writes it back to the destination. It sits between the SIMD instruction decoder and the ALU/scratchpad pair: it initiates the transactions the ALU answers.

## Interface
Parameters:
- FUNCTION_BITS, 4, ALU function-code width
- BIT_WIDTH, 32, element width (signed)
- ADDR_WIDTH, 10, scratchpad address width
- COUNT_WIDTH, 16, element-count width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_fn  in  FUNCTION_BITS  ALU function code
- cmd_src0_base, cmd_src1_base, cmd_dst_base  in  ADDR_WIDTH each  start addresses
- cmd_count  in  COUNT_WIDTH  number of elements (0 legal)
- rd_en  out  1  scratchpad read strobe
- rd_addr0, rd_addr1  out  ADDR_WIDTH  operand addresses
- rd_data0, rd_data1  in  BIT_WIDTH  read data, valid exactly 1 cycle after rd_en
- alu_fn  out  FUNCTION_BITS  to ALU fn
- alu_in0, alu_in1, alu_acc  out  BIT_WIDTH  to ALU data_in0/data_in1/data_acc
- alu_out  in  BIT_WIDTH  ALU data_out (combinational from alu_* outputs)
- wr_en  out  1  result write strobe
- wr_addr  out  ADDR_WIDTH  result address
- wr_data  out  BIT_WIDTH  result
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: cmd_ready=1. On cmd_valid, latch fn, bases, and count.
  - count==0: assert done next cycle and stay in IDLE.
  - count>0: go to RUN.
- RUN: rd_en=1 every cycle.
  - Element i reads rd_addr0=src0_base+i and rd_addr1=src1_base+i.
  - A remaining counter decrements once per read.
  - After the last read is issued, go to DRAIN.
- Stage 2, the cycle after each rd_en: alu_in0=rd_data0, alu_in1=rd_data1, alu_fn=latched fn. alu_out is registered into wr_data. wr_addr=dst_base+i. wr_en=1 in the following cycle.
- DRAIN: wait for the last write, then return to IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH; 1023+1 wraps to 0 silently.
- cmd_ready=0 outside IDLE. cmd_valid during busy is ignored, with no latching and no error.
- alu_fn, alu_in0, alu_in1 and alu_acc hold their last value when no element is in flight.
- Reset, including mid-command: all in-flight elements are dropped with no further writes, and the block returns to IDLE.
- Reset values: cmd_ready=1; rd_en, wr_en, busy and done are 0; all address, data and ALU outputs are 0.

## Timing
- Command accepted at cycle A (cmd_valid & cmd_ready).
- Element i: rd_en at A+1+i; ALU inputs driven at A+2+i; wr_en at A+3+i.
- Throughput: 1 element/cycle, with no bubbles.
- done is asserted in the same cycle as the last wr_en, i.e. A+2+count. busy falls and cmd_ready rises the next cycle. The next command can be accepted at A+3+count.
- count==0: done at A+1; cmd_ready stays 1.
- busy=1 from A+1 through the done cycle inclusive.

## Configuration
- SIMD_SEQ_REDUCE_EN defined:
  - Adds input port cmd_reduce (1 bit), latched at accept.
  - When cmd_reduce=1:
    - Element 0 uses alu_in1=rd_data1.
    - Element i>0 uses alu_in1=acc, where acc is the registered previous alu_out.
    - alu_acc=acc.
    - Only the final result is written, once, at dst_base, with wr_en at A+2+count.
    - done timing is unchanged.
  - cmd_reduce=0 behaves exactly as in the non-macro build.
- Macro undefined: no cmd_reduce port, no acc register; alu_acc is tied to 0.

## Structure
- Shared package simd_pkg:
  - state encoding typedef (IDLE/RUN/DRAIN);
  - ALU function-code constants (ADD=0, SUB=1, SHR=7, SHL=8, etc.);
  - default width constants.
- Sub-module simd_seq_addr_gen: base register plus offset counter with modulo wrap. Instantiated three times (src0, src1, dst).
- The FSM and datapath pipeline registers live in the top module.

## Test plan
- ADD, count=4, src0=[1,2,3,4], src1=[10,20,30,40] → writes 11,22,33,44 at dst..dst+3 on consecutive cycles A+3..A+6; done at A+6.
- SUB, count=1, 0x80000000-1 → the ALU-saturated value 0x80000000 is written; busy high for 3 cycles.
- count=0 → no rd_en and no wr_en; done pulse at A+1; cmd_ready never drops.
- Wrap: src0_base=1022, count=3 → rd_addr0 sequence 1022, 1023, 0.
- Reset asserted at A+3 of a count=8 command → no wr_en after reset; cmd_ready=1 the cycle after reset deasserts; second command then completes correctly.
- (SIMD_SEQ_REDUCE_EN) ADD, reduce=1, count=4, src0=[1,2,3,4], src1[0]=100 → single write of 110 at dst_base at A+6.
